// File: rtl/dram_write_buffer.sv
// dram_write_buffer: write-back FIFO between the L2 block port and DRAM.
// Write-backs are buffered and drained to DRAM in idle slots; reads bypass the
// FIFO and are forwarded from the newest matching buffered block on a hit.
// Optional feature macro: WBUF_COALESCE_EN (merge writes to an already
// buffered block in place instead of allocating a new entry).
module dram_write_buffer #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned BLOCK_W = 128,
   parameter int unsigned DEPTH   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  cache_addr,
   input  logic               cache_en,
   input  logic               cache_we,
   input  logic [BLOCK_W-1:0] cache_din,
   output logic [BLOCK_W-1:0] cache_dout,
   output logic               cache_dready,
   output logic               cache_accR,
   output logic               cache_accW,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_en,
   output logic               mem_we,
   output logic [BLOCK_W-1:0] mem_din,
   input  logic [BLOCK_W-1:0] mem_dout,
   input  logic               mem_dready,
   input  logic               mem_accR,
   input  logic               mem_accW,
   input  logic               flush,
   output logic               flushed
);

   localparam int unsigned OFF_W = $clog2(BLOCK_W / 8);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FWD     = 2'd1,
      S_RD_REQ  = 2'd2,
      S_RD_WAIT = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next_state;

   logic [ADDR_W-1:0]   r_addr [DEPTH];
   logic [BLOCK_W-1:0]  r_data [DEPTH];
   logic [PTR_W-1:0]    r_wptr;
   logic [PTR_W-1:0]    r_rptr;
   logic [CNT_W-1:0]    r_count;

   logic                r_flushing;
   logic                r_flushed;
   logic                r_dready;
   logic [BLOCK_W-1:0]  r_dout;
   logic                r_mem_en;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [BLOCK_W-1:0]  r_mem_din;
   logic [ADDR_W-1:0]   r_rd_addr;

   logic [ADDR_W-1:0]   w_blk;
   logic                w_full;
   logic                w_empty;
   logic                w_hit;
   logic [PTR_W-1:0]    w_hit_idx;
   logic                w_rd_acc;
   logic                w_wr_acc;
   logic                w_coal;
   logic                w_push;
   logic                w_pop;
   logic                w_drain;
   logic                w_fwd;
   logic                w_issue_rd;
   logic                w_rd_done;
   logic                w_flush_done;

   assign w_blk   = cache_addr & BLK_MASK;
   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);

   assign cache_accW = ~reset & ~w_full & ~r_flushing;
   assign cache_accR = ~reset & (r_state == S_IDLE) & ~r_flushing;

   // Write has priority when en and we arrive together.
   assign w_rd_acc = cache_en & ~cache_we & cache_accR;

   // Newest live entry matching the requested block (scan oldest to newest).
   always_comb begin : hit_search
      logic [PTR_W-1:0] v_idx;
      v_idx     = r_rptr;
      w_hit     = 1'b0;
      w_hit_idx = r_rptr;
      for (int i = 0; i < int'(DEPTH); i++) begin
         v_idx = r_rptr + PTR_W'(i);
         if ((CNT_W'(i) < r_count) && (r_addr[v_idx] == w_blk)) begin
            w_hit     = 1'b1;
            w_hit_idx = v_idx;
         end
      end
   end

`ifdef WBUF_COALESCE_EN
   // Merge into a live entry unless that entry is the head leaving this cycle.
   assign w_coal = cache_we & w_hit & ~(w_pop & (w_hit_idx == r_rptr));
`else
   assign w_coal = 1'b0;
`endif

   assign w_wr_acc = cache_we & ~reset & ~r_flushing & (~w_full | w_coal);
   assign w_push   = w_wr_acc & ~w_coal;
   assign w_pop    = w_drain;

   // Flush completes once the FIFO is empty with no read in progress.
   assign w_flush_done = (flush | r_flushing) & (r_state == S_IDLE) & w_empty
                         & ~w_push & ~w_rd_acc;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state and control strobes; reads take priority over draining.
   always_comb begin
      w_next_state = r_state;
      w_drain      = 1'b0;
      w_fwd        = 1'b0;
      w_issue_rd   = 1'b0;
      w_rd_done    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_rd_acc) begin
               if (w_hit) begin
                  w_fwd        = 1'b1;
                  w_next_state = S_FWD;
               end else begin
                  w_next_state = S_RD_REQ;
               end
            end else if (~w_empty && mem_accW && ~r_mem_we) begin
               w_drain = 1'b1;
            end
         end
         S_FWD: w_next_state = S_IDLE;
         S_RD_REQ: begin
            if (mem_accR) begin
               w_issue_rd   = 1'b1;
               w_next_state = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (mem_dready) begin
               w_rd_done    = 1'b1;
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // FIFO storage: allocate at the tail or overwrite a coalesced entry.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_wptr] <= w_blk;
         r_data[r_wptr] <= cache_din;
      end else if (w_wr_acc && w_coal) begin
         r_data[w_hit_idx] <= cache_din;
      end
   end

   // DRAM-side command registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_en   <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_din  <= '0;
         r_rd_addr  <= '0;
      end else begin
         r_mem_en <= w_issue_rd;
         r_mem_we <= w_drain;
         if (w_issue_rd)   r_mem_addr <= r_rd_addr;
         else if (w_drain) r_mem_addr <= r_addr[r_rptr];
         if (w_drain)      r_mem_din  <= r_data[r_rptr];
         if (w_rd_acc)     r_rd_addr  <= w_blk;
      end
   end

   // Cache-side read return and flush handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dready   <= 1'b0;
         r_dout     <= '0;
         r_flushing <= 1'b0;
         r_flushed  <= 1'b0;
      end else begin
         r_dready <= w_fwd | w_rd_done;
         if (w_fwd)          r_dout <= r_data[w_hit_idx];
         else if (w_rd_done) r_dout <= mem_dout;
         r_flushed  <= w_flush_done;
         r_flushing <= (r_flushing | flush) & ~w_flush_done;
      end
   end

   assign cache_dout   = r_dout;
   assign cache_dready = r_dready;
   assign mem_addr     = r_mem_addr;
   assign mem_en       = r_mem_en;
   assign mem_we       = r_mem_we;
   assign mem_din      = r_mem_din;
   assign flushed      = r_flushed;

endmodule
